shift_sequencer: RTL

Multicycle controller that sequences the shift register and its input-select mux for shift-class instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV) and for plain register loads. On a `start` from the main control unit it selects the shift source via `DisRegE`, loads the shift register, and issues the required shift steps. It then pulses `wr_en` and `done` so the result can be written back. It sits between the main control FSM and the shift datapath (input mux plus shift register).

---
 rtl/shift_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multicycle controller for shift-class instructions and plain
// register loads. Selects the shift source, loads the shift register, issues
// up to MAX_STEP bits of shift per cycle, then requests write-back.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               request pulse, only honoured in IDLE
//   op[2:0]             operation, captured on accepted start
//   shamt[4:0]          instruction shift amount, captured on accepted start
//   rs_amt[4:0]         register-A shift amount, captured on accepted start
//   DisRegE[1:0]        shift-source mux select (00 B, 01 A, 10 imm<<2)
//   ShiftCtrl[2:0]      shift register command (hold/load/sll/srl/sra)
//   ShiftN[4:0]         bits shifted this cycle
//   busy, done, wr_en   status and write-back request
module shift_sequencer #(
    parameter int unsigned MAX_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [4:0] shamt,
    input  logic [4:0] rs_amt,
    output logic [1:0] DisRegE,
    output logic [2:0] ShiftCtrl,
    output logic [4:0] ShiftN,
    output logic       busy,
    output logic       done,
    output logic       wr_en
);

    localparam int unsigned AMT_W  = 5;
    localparam logic [AMT_W-1:0] STEP = AMT_W'(MAX_STEP);

    localparam logic [2:0] CTRL_HOLD = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b001;
    localparam logic [2:0] CTRL_SLL  = 3'b010;
    localparam logic [2:0] CTRL_SRL  = 3'b011;
    localparam logic [2:0] CTRL_SRA  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WRITE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] step;

    logic [1:0]       dis_d;
    logic [2:0]       ctrl_d;
    logic [AMT_W-1:0] n_d;
    logic             busy_d, done_d, wr_d;

    // Shift-source select for an operation
    function automatic logic [1:0] src_of(input logic [2:0] o);
        if (o == 3'b110)      return 2'b10;
        else if (o == 3'b111) return 2'b01;
        else                  return 2'b00;
    endfunction

    // Shift amount for an operation: immediate, register or none
    function automatic logic [AMT_W-1:0] amt_of(input logic [2:0] o,
                                                input logic [AMT_W-1:0] sh,
                                                input logic [AMT_W-1:0] rs);
        if (o <= 3'b010)      return sh;
        else if (o <= 3'b101) return rs;
        else                  return '0;
    endfunction

    // Shift direction command for an operation
    function automatic logic [2:0] dir_of(input logic [2:0] o);
        case (o)
            3'b000, 3'b011: return CTRL_SLL;
            3'b001, 3'b101: return CTRL_SRL;
            default:        return CTRL_SRA;
        endcase
    endfunction

    // Next state plus next registered output values. rem_q holds the count
    // still to be issued after the step currently on ShiftN, so the step is
    // decided one edge ahead and the outputs stay purely registered.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        step    = (rem_q > STEP) ? STEP : rem_q;
        dis_d   = 2'b00;
        ctrl_d  = CTRL_HOLD;
        n_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    rem_d   = amt_of(op, shamt, rs_amt);
                    state_d = S_LOAD;
                    dis_d   = src_of(op);
                    ctrl_d  = CTRL_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD, S_SHIFT: begin
                dis_d  = src_of(op_q);
                busy_d = 1'b1;
                if (rem_q != '0) begin
                    state_d = S_SHIFT;
                    rem_d   = rem_q - step;
                    ctrl_d  = dir_of(op_q);
                    n_d     = step;
                end else begin
                    state_d = S_WRITE;
                    done_d  = 1'b1;
                    wr_d    = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured fields and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 3'b000;
            rem_q     <= '0;
            DisRegE   <= 2'b00;
            ShiftCtrl <= CTRL_HOLD;
            ShiftN    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            DisRegE   <= dis_d;
            ShiftCtrl <= ctrl_d;
            ShiftN    <= n_d;
            busy      <= busy_d;
            done      <= done_d;
            wr_en     <= wr_d;
        end
    end

endmodule
